// File: rtl/controle_pkg.sv
// Shared definitions for the control/operand stage feeding the 8-bit ULA.
package controle_pkg;

   // Control FSM states
   typedef enum logic [1:0] {
      OCIOSO     = 2'd0,
      DECODIFICA = 2'd1,
      EXECUTA    = 2'd2,
      ESCRITA    = 2'd3
   } estado_t;

   // ULA opcodes; 1100-1111 are not ULA operations and are treated as NOP
   localparam logic [3:0] OP_NOP  = 4'b0000;
   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_SUB  = 4'b0010;
   localparam logic [3:0] OP_MUL  = 4'b0011;
   localparam logic [3:0] OP_DIV  = 4'b0100;
   localparam logic [3:0] OP_AND  = 4'b0101;
   localparam logic [3:0] OP_OR   = 4'b0110;
   localparam logic [3:0] OP_NOT  = 4'b0111;
   localparam logic [3:0] OP_XOR  = 4'b1000;
   localparam logic [3:0] OP_XNOR = 4'b1001;
   localparam logic [3:0] OP_LDI  = 4'b1010;
   localparam logic [3:0] OP_NOT2 = 4'b1011;

   // Instruction field positions: [15:12] op, [11:10] rd, [9:8] rs, [7:0] imm
   localparam int OP_MSB  = 15;
   localparam int OP_LSB  = 12;
   localparam int RD_MSB  = 11;
   localparam int RD_LSB  = 10;
   localparam int RS_MSB  = 9;
   localparam int RS_LSB  = 8;
   localparam int IMM_MSB = 7;
   localparam int IMM_LSB = 0;

   // Opcodes in the top quarter of the code space have no ULA meaning
   function automatic logic op_ilegal(input logic [3:0] op);
      return (op[3:2] == 2'b11);
   endfunction

endpackage

// File: rtl/banco_registradores.sv
// 4x8 register bank: one synchronous write port, three combinational read ports.
module banco_registradores #(
   parameter int DATA_W = 8,
   parameter int NREG   = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [1:0]        waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [1:0]        rd_addr,
   output logic [DATA_W-1:0] rd_dado,
   input  logic [1:0]        rs_addr,
   output logic [DATA_W-1:0] rs_dado,
   input  logic [1:0]        dbg_addr,
   output logic [DATA_W-1:0] dbg_dado
);

   logic [DATA_W-1:0] regs [NREG];

   // Storage: cleared asynchronously, written on the rising edge when we is high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end

   // Read ports: rd and rs see the pre-write value, so rd == rs is harmless
   always_comb begin
      rd_dado  = regs[rd_addr];
      rs_dado  = regs[rs_addr];
      dbg_dado = regs[dbg_addr];
   end

endmodule

// File: rtl/unidade_controle.sv
// Multi-cycle control/operand stage: accepts an instruction, reads operands,
// drives the external ULA, captures its result and writes it back.
module unidade_controle
   import controle_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int INSTR_W = 16,
   parameter int NREG    = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               instr_valid,
   output logic               instr_ready,
   input  logic [INSTR_W-1:0] instr,
   output logic [DATA_W-1:0]  ula_a,
   output logic [DATA_W-1:0]  ula_b,
   output logic [3:0]         ula_opcode,
   input  logic [DATA_W-1:0]  ula_saida,
   output logic               res_valid,
   output logic [1:0]         res_reg,
   output logic [DATA_W-1:0]  res_dado,
   output logic               div_zero,
   input  logic [1:0]         dbg_sel,
   output logic [DATA_W-1:0]  dbg_dado
);

   // Handshake: an instruction transfers on a rising edge where instr_valid and
   // instr_ready are both high; instr_ready is high only in OCIOSO, and upstream
   // must keep instr stable while instr_valid is high and not yet accepted.

   estado_t            estado;
   logic [INSTR_W-1:0] instr_q;
   logic [DATA_W-1:0]  resultado;
   logic [DATA_W-1:0]  rd_dado;
   logic [DATA_W-1:0]  rs_dado;
   logic [3:0]         op;
   logic [1:0]         rd;
   logic [1:0]         rs;
   logic [DATA_W-1:0]  imm;
   logic               wr_en;

   // Field extraction from the latched instruction
   always_comb begin
      op  = instr_q[OP_MSB:OP_LSB];
      rd  = instr_q[RD_MSB:RD_LSB];
      rs  = instr_q[RS_MSB:RS_LSB];
      imm = instr_q[IMM_MSB:IMM_LSB];
   end

   // Writeback happens on the edge that leaves ESCRITA, only when the strobe is up
   always_comb begin
      wr_en = (estado == ESCRITA) && res_valid;
   end

   banco_registradores #(
      .DATA_W (DATA_W),
      .NREG   (NREG)
   ) u_banco (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (wr_en),
      .waddr    (rd),
      .wdata    (resultado),
      .rd_addr  (rd),
      .rd_dado  (rd_dado),
      .rs_addr  (rs),
      .rs_dado  (rs_dado),
      .dbg_addr (dbg_sel),
      .dbg_dado (dbg_dado)
   );

   // Control FSM with all outputs registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado      <= OCIOSO;
         instr_q     <= '0;
         resultado   <= '0;
         instr_ready <= 1'b1;
         ula_a       <= '0;
         ula_b       <= '0;
         ula_opcode  <= OP_NOP;
         res_valid   <= 1'b0;
         res_reg     <= '0;
         res_dado    <= '0;
         div_zero    <= 1'b0;
      end else begin
         res_valid <= 1'b0;
         div_zero  <= 1'b0;
         case (estado)
            OCIOSO: begin
               if (instr_valid && instr_ready) begin
                  instr_q     <= instr;
                  instr_ready <= 1'b0;
                  estado      <= DECODIFICA;
               end
            end
            DECODIFICA: begin
               if (op == OP_LDI) begin
                  ula_a <= imm;
                  ula_b <= '0;
               end else begin
                  ula_a <= rd_dado;
                  ula_b <= rs_dado;
               end
               ula_opcode <= op_ilegal(op) ? OP_NOP : op;
               estado     <= EXECUTA;
            end
            EXECUTA: begin
               // ula_b still carries R[rs] here, which is the divisor for DIV
               resultado  <= ula_saida;
               ula_opcode <= OP_NOP;
               if (op == OP_DIV && ula_b == '0) begin
                  div_zero <= 1'b1;
               end else if (op != OP_NOP && !op_ilegal(op)) begin
                  res_valid <= 1'b1;
                  res_reg   <= rd;
                  res_dado  <= ula_saida;
               end
               estado <= ESCRITA;
            end
            ESCRITA: begin
               instr_ready <= 1'b1;
               estado      <= OCIOSO;
            end
            default: begin
               instr_ready <= 1'b1;
               ula_opcode  <= OP_NOP;
               estado      <= OCIOSO;
            end
         endcase
      end
   end

endmodule

// File: doc/unidade_controle.md
Name: unidade_controle

Overview:
- Multi-cycle control/operand stage directly upstream of the 8-bit ULA.
- Accepts 16-bit instructions over a valid/ready handshake and decodes them.
- Reads operands from an internal 4x8 register bank and drives the ULA `a`/`b`/`opcode`.
- Captures the ULA result, writes it back to the bank and reports the writeback on a result strobe.

Parameters:
- DATA_W, 8, datapath width; must match the ULA width.
- INSTR_W, 16, instruction width.
- NREG, 4, register bank depth; fixed at 4 because register fields are 2 bits.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  upstream presents an instruction.
- instr_ready  out  1  block accepts an instruction this cycle.
- instr  in  16  [15:12] op, [11:10] rd, [9:8] rs, [7:0] imm.
- ula_a  out  8  ULA operand a.
- ula_b  out  8  ULA operand b.
- ula_opcode  out  4  ULA opcode.
- ula_saida  in  8  ULA combinational result.
- res_valid  out  1  one-cycle writeback strobe.
- res_reg  out  2  destination register of the writeback.
- res_dado  out  8  value written.
- div_zero  out  1  one-cycle pulse: division by zero suppressed.
- dbg_sel  in  2  debug register select.
- dbg_dado  out  8  combinational read of R[dbg_sel].

Behaviour:
- Reset, asynchronous, active-low:
  - R0..R3 = 0; FSM = OCIOSO.
  - instr_ready = 1 (OCIOSO).
  - res_valid = 0, div_zero = 0, res_reg = 0, res_dado = 0.
  - ula_a = 0, ula_b = 0, ula_opcode = 0000.
- FSM states: OCIOSO -> DECODIFICA -> EXECUTA -> ESCRITA -> OCIOSO.
  - OCIOSO: instr_ready = 1. On instr_valid & instr_ready, latch instr and go to DECODIFICA. Otherwise stay.
  - DECODIFICA: read R[rd] and R[rs]; register the ULA drive values.
    - op 1010 (load immediate): ula_a = imm, ula_b = 0.
    - All other ops: ula_a = R[rd], ula_b = R[rs].
    - ula_opcode = op, or 0000 for ops 1100-1111.
  - EXECUTA: ULA inputs are stable for the whole cycle. Sample ula_saida into a result register at the end of the cycle.
  - ESCRITA: resolve the instruction, then return to OCIOSO.
    - Normal case: write R[rd] = result; res_valid = 1 for one cycle; res_reg = rd; res_dado = result.
    - No writeback and res_valid = 0 for: op 0000 (NOP); ops 1100-1111 (illegal, treated as NOP); op 0100 with R[rs] = 0.
    - Division by zero (op 0100, R[rs] = 0): div_zero = 1 for one cycle.
- ULA drive outside EXECUTA:
  - ula_opcode = 0000 in OCIOSO and ESCRITA.
  - ula_a/ula_b hold their last values.
- Timing:
  - Acceptance edge = cycle 0; res_valid is high in cycle 3.
  - instr_ready is low in DECODIFICA, EXECUTA and ESCRITA.
  - Maximum throughput is one instruction per 4 cycles.
  - instr_valid held while busy is not consumed; upstream must hold instr stable until the handshake.
- Arithmetic: all results are truncated to 8 bits by the ULA. Wrap-around on add, sub and mul is expected; no carry or overflow flag.
- rd == rs is legal; both operands read the same pre-write value.
- dbg_dado reflects the write from the edge after ESCRITA.
- Reset asserted mid-instruction aborts it: no writeback, no strobe, registers cleared.

Decomposition:
- Shared package `controle_pkg`:
  - FSM state enum (OCIOSO, DECODIFICA, EXECUTA, ESCRITA).
  - ULA opcode constants 0000-1011 with names (OP_NOP, OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_NOT, OP_XOR, OP_XNOR, OP_LDI, OP_NOT2).
  - Instruction field bit positions.
- One sub-module: `banco_registradores`.
  - 4x8 storage with asynchronous active-low clear.
  - 1 write port plus 3 combinational read ports: rd, rs, dbg.
- FSM and decode stay in `unidade_controle`.

Test Plan:
- Reset then idle: all outputs at reset values; instr_ready = 1; dbg_dado = 0 for every dbg_sel.
- Load immediate, instr = 0xA425 (LDI R1, 0x25):
  - instr_ready low for 3 cycles.
  - ula_opcode = 1010, ula_a = 0x25 in EXECUTA.
  - Cycle 3: res_valid = 1, res_reg = 1, res_dado = 0x25; then dbg_sel = 1 reads 0x25.
- Add with wrap-around: with R1 = 0x25 and R2 = 0xF0, instr = 0x1600 (ADD R1, R2) -> res_dado = 0x15, R1 = 0x15.
- Multiply truncation: with R1 = 0x10 and R2 = 0x20, MUL R1, R2 -> res_dado = 0x00.
- Division by zero: with R3 = 0x40 and R0 = 0, instr = 0x4C00 (DIV R3, R0) -> div_zero pulses in cycle 3, res_valid = 0, R3 stays 0x40.
- Back-to-back and reset:
  - instr_valid held high with two instructions -> second accepted exactly 4 cycles after the first.
  - An illegal op 1111 -> no strobe.
  - rst_n low during EXECUTA -> FSM returns to OCIOSO, registers read 0, no res_valid.
